// File: rtl/mdr_pkg.sv
// mdr_pkg: shared defaults and helpers for the instruction-word FIFO
// (mdr_fifo) sitting between instruction memory and decode.
//   MDR_WIDTH_DEF / MDR_DEPTH_DEF : default word width and entry count
//   mdr_word_t                    : one instruction word at default width
//   mdr_cnt_w(depth)              : width of an occupancy counter that
//                                   must represent 0..depth inclusive
package mdr_pkg;

    localparam int MDR_WIDTH_DEF = 67;
    localparam int MDR_DEPTH_DEF = 4;

    typedef logic [MDR_WIDTH_DEF-1:0] mdr_word_t;

    // One extra bit over the pointer width so that "full" (== depth)
    // is distinguishable from "empty" (== 0).
    function automatic int mdr_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mdr_fifo_if.sv
// mdr_fifo_if: write and read valid/ready handshakes of mdr_fifo.
//   wr_valid/wr_ready/wr_data : producer side (instruction memory)
//   rd_valid/rd_ready/rd_data : consumer side (decode)
// Modports:
//   master : the environment around the FIFO (drives wr_*, rd_ready)
//   slave  : the FIFO itself (drives wr_ready, rd_valid, rd_data)
interface mdr_fifo_if
    import mdr_pkg::*;
#(
    parameter int WIDTH = MDR_WIDTH_DEF
);

    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/mdr_wrap_ptr.sv
// mdr_wrap_ptr: W-bit pointer that wraps naturally from 2**W-1 to 0.
//   clk : rising-edge clock
//   clr : synchronous clear to 0 (reset or flush), wins over inc
//   inc : advance by one this edge
//   ptr : current pointer value
module mdr_wrap_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + W'(1);
    end

endmodule

// File: rtl/mdr_fifo.sv
// mdr_fifo: DEPTH-entry instruction-word buffer between instruction
// memory and decode, with valid/ready on both sides, occupancy status and
// a flush for branch redirects.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (drops all entries)
//   flush : drops all entries at the next edge; same-cycle push/pop lost
//   bus   : mdr_fifo_if.slave (wr_valid/wr_ready/wr_data,
//           rd_valid/rd_ready/rd_data)
//   count : occupancy 0..DEPTH
//   full  : count == DEPTH
//   empty : count == 0
// DEPTH must be a power of two and at least 2 so the pointers wrap
// without compare logic.
// Optional macro MDR_FIFO_BYPASS_EN: when the buffer is empty a word
// offered on the write side falls straight through to the read side in
// the same cycle; if decode takes it, it is never stored.
module mdr_fifo
    import mdr_pkg::*;
#(
    parameter int WIDTH = MDR_WIDTH_DEF,
    parameter int DEPTH = MDR_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    mdr_fifo_if.slave                    bus,
    output logic [mdr_cnt_w(DEPTH)-1:0]  count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = mdr_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             clr;
    logic             push;
    logic             pop;

    assign clr = rst | flush;

    // Status comes from the occupancy register only; pointers are equal
    // both when empty and when full.
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    assign bus.wr_ready = !full;

`ifdef MDR_FIFO_BYPASS_EN
    logic byp;
    logic byp_take;

    // Fall-through is only offered when nothing older is queued, so order
    // is preserved.
    assign byp          = empty && bus.wr_valid && !flush;
    assign byp_take     = byp && bus.rd_ready;
    assign bus.rd_valid = !empty || byp;
    assign bus.rd_data  = empty ? bus.wr_data : mem[rd_ptr];
    // A word consumed straight through is never written.
    assign push         = bus.wr_valid && bus.wr_ready && !byp_take;
`else
    assign bus.rd_valid = !empty;
    assign bus.rd_data  = mem[rd_ptr];
    assign push         = bus.wr_valid && bus.wr_ready;
`endif

    // Only stored words count as pops; a bypassed word leaves state alone.
    assign pop = !empty && bus.rd_ready;

    mdr_wrap_ptr #(.W(AW)) u_wr_ptr (
        .clk (clk),
        .clr (clr),
        .inc (push),
        .ptr (wr_ptr)
    );

    mdr_wrap_ptr #(.W(AW)) u_rd_ptr (
        .clk (clk),
        .clr (clr),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Array is never reset; a cycle with rst or flush must not leave a
    // word behind, so writes are suppressed then as well.
    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (clr)
            cnt_q <= '0;
        else if (push && !pop)
            cnt_q <= cnt_q + CW'(1);
        else if (pop && !push)
            cnt_q <= cnt_q - CW'(1);
    end

endmodule

// File: tb/tb_mdr_fifo.sv
// tb_mdr_fifo: directed scenarios followed by random traffic on mdr_fifo,
// checked every cycle against a queue model of the buffer, plus literal
// expectations on the directed scenarios. Honours MDR_FIFO_BYPASS_EN.
module tb_mdr_fifo;
    import mdr_pkg::*;

    localparam int WIDTH = 67;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          chk_en = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] q[$];

    mdr_fifo_if #(.WIDTH(WIDTH)) bus ();

    mdr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update: a queue of stored words.
    always @(posedge clk) begin
        int   n;
        logic push, pop, byp;
        n   = q.size();
        byp = 1'b0;
        if (rst || flush) begin
            q.delete();
        end else begin
`ifdef MDR_FIFO_BYPASS_EN
            byp = (n == 0) && bus.wr_valid && bus.rd_ready;
`endif
            push = bus.wr_valid && (n < DEPTH) && !byp;
            pop  = (n > 0) && bus.rd_ready;
            if (pop)
                void'(q.pop_front());
            if (push)
                q.push_back(bus.wr_data);
        end
    end

    // Compare process: outputs against the model, mid-cycle.
    always @(negedge clk) begin
        int               n;
        logic             byp, exp_rv;
        logic [WIDTH-1:0] exp_rd;
        if (chk_en) begin
            n   = q.size();
            byp = 1'b0;
`ifdef MDR_FIFO_BYPASS_EN
            byp = (n == 0) && bus.wr_valid && !flush;
`endif
            exp_rv = (n > 0) || byp;
            exp_rd = (n > 0) ? q[0] : bus.wr_data;
            cmp("m_count",    WIDTH'(count),        WIDTH'(n));
            cmp("m_full",     WIDTH'(full),         WIDTH'(n == DEPTH));
            cmp("m_empty",    WIDTH'(empty),        WIDTH'(n == 0));
            cmp("m_wr_ready", WIDTH'(bus.wr_ready), WIDTH'(n < DEPTH));
            cmp("m_rd_valid", WIDTH'(bus.rd_valid), WIDTH'(exp_rv));
            if (exp_rv)
                cmp("m_rd_data", bus.rd_data, exp_rd);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [95:0] r;
        rst          = 1'b1;
        flush        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        step(2);
        chk_en = 1'b1;
        rst    = 1'b0;
        cmp("rst_count",    WIDTH'(count),        WIDTH'(0));
        cmp("rst_empty",    WIDTH'(empty),        WIDTH'(1));
        cmp("rst_full",     WIDTH'(full),         WIDTH'(0));
        cmp("rst_wr_ready", WIDTH'(bus.wr_ready), WIDTH'(1));
        cmp("rst_rd_valid", WIDTH'(bus.rd_valid), WIDTH'(0));

        // Fill to full with rd_ready low.
        for (int i = 1; i <= 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = WIDTH'(i);
            step();
            cmp("fill_count", WIDTH'(count), WIDTH'(i));
        end
        cmp("fill_full",     WIDTH'(full),         WIDTH'(1));
        cmp("fill_wr_ready", WIDTH'(bus.wr_ready), WIDTH'(0));
        cmp("fill_rd_data",  bus.rd_data,          WIDTH'(1));

        // Pop while full with a word offered: the word is refused.
        bus.wr_data  = WIDTH'(5);
        bus.rd_ready = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        cmp("fullpop_count",   WIDTH'(count), WIDTH'(3));
        cmp("fullpop_rd_data", bus.rd_data,   WIDTH'(2));

        // Down to 2, then 10 cycles of push+pop across pointer wrap.
        bus.rd_ready = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = WIDTH'(16 + i);
            step();
            cmp("stream_count", WIDTH'(count), WIDTH'(2));
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        cmp("stream_rd_data", bus.rd_data, WIDTH'(24));

        // Three entries, then flush with a concurrent write.
        bus.wr_valid = 1'b1;
        bus.wr_data  = WIDTH'(32);
        step();
        cmp("pre_flush_count", WIDTH'(count), WIDTH'(3));
        flush       = 1'b1;
        bus.wr_data = WIDTH'(33);
        step();
        flush        = 1'b0;
        bus.wr_valid = 1'b0;
        cmp("flush_count",    WIDTH'(count),        WIDTH'(0));
        cmp("flush_empty",    WIDTH'(empty),        WIDTH'(1));
        cmp("flush_rd_valid", WIDTH'(bus.rd_valid), WIDTH'(0));

        // Reset mid-stream with 2 entries and a pop request.
        bus.wr_valid = 1'b1;
        bus.wr_data  = WIDTH'(48);
        step();
        bus.wr_data  = WIDTH'(49);
        step();
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b1;
        rst          = 1'b1;
        step();
        rst          = 1'b0;
        bus.rd_ready = 1'b0;
        cmp("midrst_count",    WIDTH'(count),        WIDTH'(0));
        cmp("midrst_wr_ready", WIDTH'(bus.wr_ready), WIDTH'(1));

        // Empty buffer, word offered with decode ready.
        bus.wr_valid = 1'b1;
        bus.wr_data  = WIDTH'(12'hABC);
        bus.rd_ready = 1'b1;
        #1;
`ifdef MDR_FIFO_BYPASS_EN
        cmp("byp_rd_valid", WIDTH'(bus.rd_valid), WIDTH'(1));
        cmp("byp_rd_data",  bus.rd_data,          WIDTH'(12'hABC));
`else
        cmp("nobyp_rd_valid", WIDTH'(bus.rd_valid), WIDTH'(0));
`endif
        step();
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        #1;
`ifdef MDR_FIFO_BYPASS_EN
        cmp("byp_next_count", WIDTH'(count), WIDTH'(0));
`else
        cmp("nobyp_next_count",    WIDTH'(count),        WIDTH'(1));
        cmp("nobyp_next_rd_valid", WIDTH'(bus.rd_valid), WIDTH'(1));
        cmp("nobyp_next_rd_data",  bus.rd_data,          WIDTH'(12'hABC));
`endif

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            r            = {$urandom(), $urandom(), $urandom()};
            bus.wr_valid = ($urandom_range(3, 0) != 0);
            bus.rd_ready = ($urandom_range(2, 0) != 0);
            bus.wr_data  = r[WIDTH-1:0];
            flush        = ($urandom_range(31, 0) == 0);
            rst          = ($urandom_range(63, 0) == 0);
            step();
        end
        rst          = 1'b0;
        flush        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
